// File: rtl/neonfox_hazard_pkg.sv
// Shared types and index constants for the NeonFox interlock unit.
// Channel and stall-source positions name the bits of issue_wr/issue_rd and stall_req.
package neonfox_hazard_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXTEND = 1'b1
    } flush_state_t;

    localparam int CH_IO    = 0;
    localparam int CH_DATA  = 1;
    localparam int CH_FLAGS = 2;
    localparam int CH_CA    = 3;

    localparam int ST_HALT  = 0;
    localparam int ST_RMISS = 1;
    localparam int ST_WMISS = 2;

    localparam int FLUSH_CNT_W = 4;
    localparam int STALL_CNT_W = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc16(input logic [STALL_CNT_W-1:0] v);
        return (v == {STALL_CNT_W{1'b1}}) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hazard_flush_seq.sv
// Decoder input flush sequencer: stretches an extended redirect to FLUSH_CYCLES cycles.
// Interrupts and plain extended redirects still flush combinationally in the same cycle.
module hazard_flush_seq
    import neonfox_hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic redirect,
    input  logic interrupt,
    input  logic extend_flush,
    output logic decoder_input_flush
);

    localparam bit CAN_EXTEND = (FLUSH_CYCLES > 1);
    localparam logic [FLUSH_CNT_W-1:0] RELOAD =
        CAN_EXTEND ? FLUSH_CNT_W'(FLUSH_CYCLES - 2) : '0;

    flush_state_t           state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   ext_redirect;

    assign ext_redirect = redirect & extend_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts the extension cycles still owed after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ext_redirect && CAN_EXTEND) begin
                    state_d = EXTEND;
                    cnt_d   = RELOAD;
                end
            end
            EXTEND: begin
                if (ext_redirect) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        decoder_input_flush = rst | interrupt | ext_redirect | (state_q == EXTEND);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// NeonFox pipeline interlock: per-channel write scoreboard, external stall merge,
// flush generation and a saturating stall-cycle profiling counter.
module hazard_scoreboard
    import neonfox_hazard_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 2,
    parameter int NUM_STALL    = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [NUM_CH-1:0]      issue_wr,
    input  logic [NUM_CH-1:0]      issue_rd,
    input  logic [NUM_STALL-1:0]   stall_req,
    input  logic                   redirect,
    input  logic                   interrupt,
    input  logic                   extend_flush,
    input  logic                   stat_clr,
    output logic                   hazard,
    output logic                   decoder_output_flush,
    output logic                   decoder_input_flush,
    output logic [NUM_CH-1:0]      pending,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Index 0 is the youngest stage; writes fall off after index DEPTH-1.
    logic [NUM_CH-1:0]      pend_q [DEPTH];
    logic [NUM_CH-1:0]      pend_d [DEPTH];
    logic [NUM_CH-1:0]      pend_or;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   ext, raw, hazard_int, bubble;

    always_comb begin
        pend_or = '0;
        for (int s = 0; s < DEPTH; s++) begin
            pend_or = pend_or | pend_q[s];
        end
    end

    // The issuing instruction's own write is not in pend yet, so it never self-blocks.
    assign ext        = |stall_req;
    assign raw        = issue_valid & (|(issue_rd & pend_or));
    assign hazard_int = ext | raw;
    assign bubble     = raw | redirect | interrupt;

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            pend_d[s] = pend_q[s];
        end
        if (!ext) begin
            if (bubble || !issue_valid) begin
                pend_d[0] = '0;
            end else begin
                pend_d[0] = issue_wr;
            end
            for (int s = 1; s < DEPTH; s++) begin
                pend_d[s] = pend_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                pend_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                pend_q[s] <= pend_d[s];
            end
        end
    end

    // A clear wins over an increment in the same cycle.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = '0;
        end else if (hazard_int) begin
            stall_count_d = sat_inc16(stall_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    hazard_flush_seq #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_seq (
        .clk                 (clk),
        .rst                 (rst),
        .redirect            (redirect),
        .interrupt           (interrupt),
        .extend_flush        (extend_flush),
        .decoder_input_flush (decoder_input_flush)
    );

    // Outputs are forced quiet while reset is held.
    always_comb begin
        hazard               = ~rst & hazard_int;
        decoder_output_flush = ~rst & (redirect | interrupt);
        pending              = rst ? '0 : pend_or;
        stall_count          = stall_count_q;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline interlock unit for the NeonFox CPU. It replaces fixed per-signal hazard equations with a per-channel write scoreboard `DEPTH` stages deep, an external stall merge, and a multi-cycle flush sequencer. It sits beside the decoder and drives the global `hazard` stall and the decoder flushes. It also keeps a saturating stall-cycle counter for profiling.

## Interface
Parameters:
- `NUM_CH`, default 4: tracked channels (IO, data, flags/nzp, call address).
- `DEPTH`, default 2: stages between issue and write visibility; range 1–8.
- `NUM_STALL`, default 3: external stall sources (halt, d-cache read miss, d-cache write miss).
- `FLUSH_CYCLES`, default 2: decoder input flush length on an extended redirect; range 1–15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset.
- `issue_valid`  in  1  instruction present in decode.
- `issue_wr`  in  NUM_CH  channels the decode instruction writes (select, address or wren).
- `issue_rd`  in  NUM_CH  channels the decode instruction reads (IO_ren, data_ren, status_ren, brx, jmp/call).
- `stall_req`  in  NUM_STALL  external stall sources.
- `redirect`  in  1  stage-1 control transfer (taken brx, jmp, call, ret).
- `interrupt`  in  1  interrupt accepted.
- `extend_flush`  in  1  extend the flush into the decoder input.
- `stat_clr`  in  1  clear `stall_count`.
- `hazard`  out  1  freeze fetch/decode.
- `decoder_output_flush`  out  1  kill decoder output.
- `decoder_input_flush`  out  1  kill decoder input.
- `pending`  out  NUM_CH  OR of all scoreboard stages.
- `stall_count`  out  16  saturating count of cycles with `hazard` high.

## Operation
- Scoreboard: `pend[1..DEPTH]`, each `NUM_CH` bits wide.
- `raw = issue_valid & |(issue_rd & pending)`.
- `ext = |stall_req`.
- `hazard = ext | raw`. This output is combinational.
- Scoreboard update, in priority order:
  - `ext`: all stages hold (pipeline frozen).
  - `raw`, `redirect` or `interrupt`: `pend[1] <= 0` (bubble); `pend[s] <= pend[s-1]`.
  - `issue_valid`: `pend[1] <= issue_wr`; shift.
  - Otherwise: `pend[1] <= 0`; shift.
  - `pend[DEPTH]` falls off the end.
- `decoder_output_flush = redirect | interrupt`. This output is combinational.
- Flush sequencer states: IDLE, EXTEND. It holds a 4-bit counter `cnt`.
  - `decoder_input_flush = interrupt | (redirect & extend_flush) | (state==EXTEND)`.
  - IDLE → EXTEND when `redirect & extend_flush & FLUSH_CYCLES>1`; `cnt <= FLUSH_CYCLES-2`.
  - EXTEND with `cnt==0` → IDLE; otherwise `cnt--`.
  - A new extended redirect while in EXTEND reloads `cnt <= FLUSH_CYCLES-2`.
  - An interrupt in EXTEND does not change `cnt`.
  - The sequencer ignores `hazard`.
- `stall_count`: increments each cycle `hazard` is high, saturating at 16'hFFFF.
  - `stat_clr` has priority and loads 0 (the same-cycle increment is dropped).

## Timing
- Reset values:
  - `pend` = 0, state IDLE, `cnt` = 0, `stall_count` = 0.
  - While `rst` is high: `hazard` = 0, `decoder_output_flush` = 0, `decoder_input_flush` = 1, `pending` = 0.
- Reset mid-EXTEND: the sequencer aborts to IDLE. Pending writes are discarded.
- Write visibility: a write issued in cycle t blocks a read of the same channel in cycles t+1 through t+DEPTH. The read may proceed at t+DEPTH+1, assuming no `ext` in between; each `ext` cycle extends the window by one.
- A read and a write of the same channel in the same issuing instruction do not self-block.
- `FLUSH_CYCLES`=1: `decoder_input_flush` matches the single-cycle combinational behaviour.
- `FLUSH_CYCLES`=N: `decoder_input_flush` stays high for exactly N consecutive cycles after an extended redirect.

## Structure
- Package `neonfox_hazard_pkg`:
  - flush state enum `flush_state_t` (IDLE, EXTEND);
  - channel index constants `CH_IO`=0, `CH_DATA`=1, `CH_FLAGS`=2, `CH_CA`=3;
  - stall index constants `ST_HALT`=0, `ST_RMISS`=1, `ST_WMISS`=2.
- Sub-module `hazard_flush_seq`: owns the state, `cnt`, and `decoder_input_flush`.
- Top level: scoreboard, hazard merge and counter.

## Test plan
- Write-to-read window. `DEPTH`=2; `issue_wr`=`CH_DATA` at t; `issue_rd`=`CH_DATA` at t+1 → `hazard` = 1 at t+1 and t+2, 0 at t+3; `pending`[1] clears after t+2.
- Freeze extends the window. `stall_req`=`ST_RMISS` at t+1 after the same write → `pend` holds; `hazard` = 1 through t+3, 0 at t+4.
- Extended flush length. `FLUSH_CYCLES`=3; `redirect` & `extend_flush` pulse at t → `decoder_output_flush` = 1 at t only; `decoder_input_flush` = 1 at t, t+1 and t+2; 0 at t+3.
- Reload in EXTEND. A second extended redirect at t+1 → `decoder_input_flush` = 1 through t+3.
- Interrupt during a raw stall → `pend[1]` gets a bubble; both flushes = 1 that cycle; no extension.
- Reset and counter. Assert `rst` in EXTEND with `pending`≠0 → next cycle everything is 0 and `decoder_input_flush` = 1. Force the counter to 16'hFFFE, then hold `hazard` for 3 cycles → `stall_count` = 16'hFFFF; `stat_clr` → 0.
